// File: rtl/relm_uart_tx.sv
// Buffered UART transmitter on a ReLM push port: 8N1 frames, or 8E1 when RELM_UART_TX_PARITY_EN is defined.
// Line falls 3 cycles after a byte is accepted by an idle block; push_retry asserts while the 2**WAD-byte FIFO is full.
module relm_uart_tx #(
  parameter int WD  = 32,
  parameter int WAD = 4,
  parameter int DIV = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [WD:0] push_d,
  output logic        push_retry,
  output logic [WD:0] stat_q,
  output logic        uart_out,
  output logic        tx_idle
);
  localparam int DEPTH = 1 << WAD;
  localparam logic [WAD:0] LEVEL_FULL = (WAD+1)'(DEPTH);
  localparam logic [15:0]  BAUD_LAST  = 16'(DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
`ifdef RELM_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY     = 3'd5;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  logic [7:0]     mem [DEPTH];
  logic [7:0]     rd_dat;
  logic [WAD-1:0] wr_ptr;
  logic [WAD-1:0] rd_ptr;
  logic [WAD:0]   level;
  logic           full;
  logic           push_acc;
  logic           pop;
  logic [2:0]     state;
  logic [15:0]    baud_cnt;
  logic           baud_end;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           unused_push_bits;
`ifdef RELM_UART_TX_PARITY_EN
  logic           par_bit;
`endif

  assign unused_push_bits = ^push_d[WD-1:8];

  assign full       = (level == LEVEL_FULL);
  assign push_retry = full;
  assign push_acc   = push_d[WD] & ~full;
  assign baud_end   = (baud_cnt == BAUD_LAST);
  // A read is issued from IDLE, or at the last STOP cycle so the next frame follows without a gap.
  assign pop        = (level != '0) && ((state == S_IDLE) || ((state == S_STOP) && baud_end));
  assign tx_idle    = (state == S_IDLE) && (level == '0);

  // Storage is not reset; flushing is done by zeroing the pointers and level.
  always_ff @(posedge clk) begin
    if (push_acc && !reset) begin
      mem[wr_ptr] <= push_d[7:0];
    end
    if (pop) begin
      rd_dat <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + WAD'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + WAD'(1);
      end
      if (push_acc && !pop) begin
        level <= level + (WAD+1)'(1);
      end else if (pop && !push_acc) begin
        level <= level - (WAD+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          shreg    <= rd_dat;
          bit_cnt  <= '0;
          baud_cnt <= '0;
          state    <= S_START;
        end
        S_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= S_AFTER_DATA;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`ifdef RELM_UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= pop ? S_LOAD : S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RELM_UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bit <= 1'b0;
    end else if (state == S_LOAD) begin
      par_bit <= ^rd_dat;
    end
  end
`endif

  // The line is registered, so every bit appears one cycle after its state; all bits keep DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_out <= 1'b1;
    end else begin
      case (state)
        S_START:  uart_out <= 1'b0;
        S_DATA:   uart_out <= shreg[0];
`ifdef RELM_UART_TX_PARITY_EN
        S_PARITY: uart_out <= par_bit;
`endif
        default:  uart_out <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q       <= '0;
      stat_q[WD-1] <= 1'b1;
      stat_q[WD-2] <= 1'b1;
    end else begin
      stat_q        <= '0;
      stat_q[WD-1]  <= ~full;
      stat_q[WD-2]  <= tx_idle;
      stat_q[WAD:0] <= level;
    end
  end

  a_level_bound: assert property (@(posedge clk) disable iff (reset) level <= LEVEL_FULL);
  a_load_to_start: assert property (@(posedge clk) disable iff (reset) (state == S_LOAD) |=> (state == S_START));
endmodule

// File: doc/relm_uart_tx.md
Name: relm_uart_tx

Overview:
- Buffered UART transmitter that terminates one ReLM push port: the CPU pushes bytes, and the block serialises them onto a TX pin as 8N1 frames (8E1 with the optional parity feature).
- Sits beside the fifo/hex/led push devices in the board top, replacing the inline transmit logic.
- Uses the standard push handshake: strobe in bit WD of the push word, combinational retry back to the CPU.
- Also exports a status word for one ReLM pop port.

Parameters:
- WD, 32, data word width; push/pop words are WD+1 bits.
- WAD, 4, log2 of TX FIFO depth (16 entries).
- DIV, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- push_d  in  WD+1  push word; bit WD = write strobe, bits 7:0 = byte, other bits ignored.
- push_retry  out  1  combinational; 1 = FIFO full, push not accepted.
- stat_q  out  WD+1  pop-port status: bit WD = 0 (never retry), bit WD-1 = not full, bit WD-2 = idle, bits WAD:0 = FIFO level, rest 0.
- uart_out  out  1  serial TX line, idle high.
- tx_idle  out  1  1 = FIFO empty and no frame in flight.

Behaviour:
- Reset values: uart_out=1, push_retry=0, tx_idle=1, level=0, stat_q = {0, 1, 1, zeros}.
- Reset at any time, including mid-frame: line forced to 1 on the next edge, frame abandoned, FIFO flushed, read/write pointers zeroed.
- FIFO: 2**WAD x 8 storage with registered read (M10K-style), wrapping pointers, level counter WAD+1 bits.
  - full = (level == 2**WAD).
  - push_retry = full, combinational from registered level.
- Push: accepted on an edge where push_d[WD]=1 and full=0; write pointer and level advance.
  - push_d[WD]=1 while full: retry=1 that cycle, nothing written. The CPU re-issues.
  - push_d[WD]=0: no effect, regardless of the other bits.
- Simultaneous push and pop on the same edge: level unchanged, both pointers advance.
  - If full, the push is still refused; retry depends on level only, never on a same-cycle pop.
- TX FSM states: IDLE, LOAD, START, DATA, [PARITY], STOP.
  - IDLE: if level>0, issue FIFO read, pop (level-1, read pointer +1), go to LOAD.
  - LOAD: latch read data into shift register, clear bit counter and baud counter, go to START.
  - START: uart_out=0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each.
  - STOP: uart_out=1 for DIV cycles. Then, if level>0, issue the next read and go directly to LOAD (back-to-back frames, no idle gap); else go to IDLE.
- Baud counter: 16 bits, counts 0..DIV-1; the bit boundary is at DIV-1. Frame length = 10*DIV cycles (11*DIV with parity).
- Latency: byte accepted at edge N with FSM in IDLE and FIFO empty → START begins (uart_out falls) after edge N+3: IDLE read at N+1, LOAD at N+2.
- tx_idle=1 only when state==IDLE and level==0.
- stat_q is registered, 1-cycle delayed view of full/idle/level.

Optional Feature:
- Macro RELM_UART_TX_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP, transmitting the even-parity bit (XOR of the 8 data bits) for DIV cycles; frame = 11*DIV cycles.
- Undefined: no PARITY state, 8N1 frames of 10*DIV cycles; no parity logic synthesised.

Test Plan:
- DIV=4, reset, push 0x55 once → uart_out falls 3 cycles after the accept edge; observed bit sequence 0,1,0,1,0,1,0,1,0,1 at 4 cycles each; tx_idle returns to 1 after 40 cycles.
- DIV=4, push 0xA3 then 0x0F on consecutive cycles → two frames back-to-back: stop bit of the first immediately followed by the start bit of the second; bytes decode LSB-first as 0xA3, 0x0F.
- WAD=2, DIV=8, push 6 bytes continuously → first accepted and dequeued, next 4 fill the FIFO, 6th sees push_retry=1 and stat_q[WD-1]=0 until the first frame completes; all 6 bytes are sent in order.
- Push with push_d[WD]=0 and data 0xFF → no frame, level stays 0, tx_idle stays 1.
- Reset asserted mid-DATA of 0x00 with 3 bytes queued → uart_out=1 next cycle, level=0, push_retry=0, no further frames.
- With RELM_UART_TX_PARITY_EN, DIV=4, push 0x07 → parity bit 1 and frame length 44 cycles; push 0x03 → parity bit 0.
